// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: command/status codes and FSM states shared by the debug bridge
package uart_dbg_pkg;
  localparam logic [7:0] CMD_WR    = 8'h10;
  localparam logic [7:0] CMD_RD    = 8'h11;
  localparam logic [7:0] ST_OK     = 8'hA5;
  localparam logic [7:0] ST_BADCMD = 8'hEE;
  localparam logic [7:0] ST_BUSTO  = 8'hEB;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_BUS_REQ,
    S_TX_STATUS,
    S_TX_DATA,
    S_TX_WAIT
  } state_t;
endpackage

// File: rtl/dbg_timeout_cnt.sv
// dbg_timeout_cnt: loadable down-counter, expires on the LOAD-th enabled cycle after a load
module dbg_timeout_cnt #(
  parameter int W    = 20,
  parameter int LOAD = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic exp_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (load_i) cnt <= W'(LOAD);
    else if (en_i && cnt != '0) cnt <= cnt - W'(1);
  end
  assign exp_o = en_i && cnt <= W'(1);
endmodule

// File: rtl/uart_dbg_ctrl.sv
// uart_dbg_ctrl: UART frame sequencer issuing 32-bit bus reads/writes and sending status bytes
module uart_dbg_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int RX_TIMEOUT_CYC  = 1_000_000,
  parameter int BUS_TIMEOUT_CYC = 4096,
  parameter int TO_W            = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_ready_i,
  input  logic [7:0]  uart_data_i,
  output logic        uart_rd_o,
  input  logic        uart_tx_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);
  state_t      state;
  logic        rd_q, tx_seen, tx_dat, take, rx_en, rx_exp, bus_exp;
  logic [1:0]  idx;
  logic [7:0]  status;
  logic [31:0] rdata;
  // rx_ready is ignored while the pop pulse and the cycle after it are in flight
  assign take   = (state inside {S_IDLE, S_RX_ADDR, S_RX_DATA}) && uart_rx_ready_i && !uart_rd_o && !rd_q;
  assign rx_en  = (state inside {S_RX_ADDR, S_RX_DATA}) && !take;
  assign busy_o = state != S_IDLE;
  dbg_timeout_cnt #(.W(TO_W), .LOAD(RX_TIMEOUT_CYC)) u_rx_to (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(take), .en_i(rx_en), .exp_o(rx_exp)
  );
  dbg_timeout_cnt #(.W(TO_W), .LOAD(BUS_TIMEOUT_CYC)) u_bus_to (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(state != S_BUS_REQ), .en_i(state == S_BUS_REQ), .exp_o(bus_exp)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      uart_rd_o   <= 1'b0;
      rd_q        <= 1'b0;
      uart_wr_o   <= 1'b0;
      uart_data_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
      tx_seen     <= 1'b0;
      tx_dat      <= 1'b0;
      idx         <= '0;
      status      <= '0;
      rdata       <= '0;
    end else begin
      uart_rd_o <= take;
      rd_q      <= uart_rd_o;
      uart_wr_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        S_IDLE: if (take) begin
          mem_we_o <= uart_data_i == CMD_WR;
          idx      <= '0;
          if (uart_data_i == CMD_WR || uart_data_i == CMD_RD) state <= S_RX_ADDR;
          else begin
            status <= ST_BADCMD;
            err_o  <= 1'b1;
            state  <= S_TX_STATUS;
          end
        end
        S_RX_ADDR: if (take) begin
          mem_addr_o <= {mem_addr_o[23:0], uart_data_i};
          idx        <= idx + 2'd1;
          if (idx == 2'd3) begin
            state     <= mem_we_o ? S_RX_DATA : S_BUS_REQ;
            mem_req_o <= !mem_we_o;
          end
        end else if (rx_exp) begin
          err_o <= 1'b1;
          state <= S_IDLE;
        end
        S_RX_DATA: if (take) begin
          mem_wdata_o <= {mem_wdata_o[23:0], uart_data_i};
          idx         <= idx + 2'd1;
          if (idx == 2'd3) begin
            state     <= S_BUS_REQ;
            mem_req_o <= 1'b1;
          end
        end else if (rx_exp) begin
          err_o <= 1'b1;
          state <= S_IDLE;
        end
        S_BUS_REQ: if (mem_ack_i) begin
          rdata     <= mem_rdata_i;
          status    <= ST_OK;
          mem_req_o <= 1'b0;
          state     <= S_TX_STATUS;
        end else if (bus_exp) begin
          status    <= ST_BUSTO;
          err_o     <= 1'b1;
          mem_req_o <= 1'b0;
          state     <= S_TX_STATUS;
        end
        S_TX_STATUS: if (!uart_tx_busy_i) begin
          uart_wr_o   <= 1'b1;
          uart_data_o <= status;
          tx_seen     <= 1'b0;
          tx_dat      <= 1'b0;
          idx         <= '0;
          state       <= S_TX_WAIT;
        end
        S_TX_DATA: if (!uart_tx_busy_i) begin
          uart_wr_o   <= 1'b1;
          uart_data_o <= rdata[31:24];
          rdata       <= {rdata[23:0], 8'h00};
          tx_seen     <= 1'b0;
          tx_dat      <= 1'b1;
          state       <= S_TX_WAIT;
        end
        S_TX_WAIT: if (uart_tx_busy_i) tx_seen <= 1'b1;
        else if (tx_seen) begin
          if (!tx_dat) state <= (status == ST_OK && !mem_we_o) ? S_TX_DATA : S_IDLE;
          else begin
            idx   <= idx + 2'd1;
            state <= idx == 2'd3 ? S_IDLE : S_TX_DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// tb_uart_dbg_ctrl: directed frames against simple UART and bus models
module tb_uart_dbg_ctrl;
  localparam int RXTO = 40;
  localparam int BUSTO = 16;
  logic clk = 0, rst_i = 1;
  logic uart_rx_ready_i = 0, uart_rd_o, uart_tx_busy_i = 1, uart_wr_o;
  logic [7:0] uart_data_i = 0, uart_data_o;
  logic mem_req_o, mem_we_o, mem_ack_i = 0, busy_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
  uart_dbg_ctrl #(.RX_TIMEOUT_CYC(RXTO), .BUS_TIMEOUT_CYC(BUSTO), .TO_W(20)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .uart_rx_ready_i(uart_rx_ready_i), .uart_data_i(uart_data_i), .uart_rd_o(uart_rd_o),
    .uart_tx_busy_i(uart_tx_busy_i), .uart_wr_o(uart_wr_o), .uart_data_o(uart_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [7:0] rxq[$], txq[$];
  int busy_cnt = 10, req_n = 0, req_cyc = 0, err_n = 0, ack_ctr = 0;
  int wr_busy_viol = 0, rd_viol = 0, wr_viol = 0, err_viol = 0;
  logic ack_en = 1, req_prev = 0, rd_prev = 0, wr_prev = 0, err_prev = 0;
  logic log_we;
  logic [31:0] log_addr, log_wdata, rdata_v = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] txb(input int i);
    return i < txq.size() ? {24'h0, txq[i]} : 32'hFFFF_FFFF;
  endfunction
  always @(negedge clk) begin
    if (uart_rd_o && rxq.size() > 0) void'(rxq.pop_front());
    uart_rx_ready_i = rxq.size() > 0;
    uart_data_i = rxq.size() > 0 ? rxq[0] : 8'h00;
    if (uart_rd_o && rd_prev) rd_viol++;
    if (uart_wr_o && wr_prev) wr_viol++;
    if (err_o && err_prev) err_viol++;
    rd_prev = uart_rd_o;
    wr_prev = uart_wr_o;
    err_prev = err_o;
    if (err_o) err_n++;
    if (uart_wr_o) begin
      if (uart_tx_busy_i) wr_busy_viol++;
      txq.push_back(uart_data_o);
      busy_cnt = 4;
    end
    uart_tx_busy_i = busy_cnt != 0;
    if (busy_cnt != 0) busy_cnt--;
    if (mem_req_o && !req_prev) begin
      req_n++;
      req_cyc = 0;
      log_we = mem_we_o;
      log_addr = mem_addr_o;
      log_wdata = mem_wdata_o;
      ack_ctr = 3;
    end
    if (mem_req_o) req_cyc++;
    req_prev = mem_req_o;
    if (mem_ack_i) mem_ack_i = 0;
    else if (mem_req_o && ack_en) begin
      if (ack_ctr == 0) begin
        mem_ack_i = 1;
        mem_rdata_i = rdata_v;
      end else ack_ctr--;
    end
  end
  task automatic send(input logic [7:0] b[]);
    foreach (b[i]) rxq.push_back(b[i]);
  endtask
  task automatic clr;
    txq.delete();
    req_n = 0;
    err_n = 0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || rxq.size() != 0) && n < 3000);
    if (n >= 3000) chk({tag, "_idle_timeout"}, 32'(busy_o), 32'(0));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_wr", 32'(uart_wr_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_i = 0;
    clr();
    send('{8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    wait_idle("wr");
    chk("wr_req_n", req_n, 1);
    chk("wr_we", 32'(log_we), 1);
    chk("wr_addr", log_addr, 32'h0000_0100);
    chk("wr_wdata", log_wdata, 32'hDEAD_BEEF);
    chk("wr_tx_n", txq.size(), 1);
    chk("wr_tx0", txb(0), 32'hA5);
    chk("wr_err_n", err_n, 0);
    clr();
    rdata_v = 32'h1234_5678;
    send('{8'h11, 8'h00, 8'h00, 8'h00, 8'h40});
    wait_idle("rd");
    chk("rd_req_n", req_n, 1);
    chk("rd_we", 32'(log_we), 0);
    chk("rd_addr", log_addr, 32'h0000_0040);
    chk("rd_tx_n", txq.size(), 5);
    chk("rd_tx0", txb(0), 32'hA5);
    chk("rd_tx1", txb(1), 32'h12);
    chk("rd_tx2", txb(2), 32'h34);
    chk("rd_tx3", txb(3), 32'h56);
    chk("rd_tx4", txb(4), 32'h78);
    clr();
    send('{8'h7F});
    wait_idle("bad");
    chk("bad_tx_n", txq.size(), 1);
    chk("bad_tx0", txb(0), 32'hEE);
    chk("bad_err_n", err_n, 1);
    chk("bad_req_n", req_n, 0);
    clr();
    rdata_v = 32'hCAFE_F00D;
    send('{8'h11, 8'h00, 8'h00, 8'h00, 8'h80});
    wait_idle("rd2");
    chk("rd2_addr", log_addr, 32'h0000_0080);
    chk("rd2_tx_n", txq.size(), 5);
    chk("rd2_tx1", txb(1), 32'hCA);
    chk("rd2_tx4", txb(4), 32'h0D);
    clr();
    send('{8'h10, 8'h00, 8'h00});
    repeat (RXTO + 30) @(negedge clk);
    chk("rxto_err_n", err_n, 1);
    chk("rxto_tx_n", txq.size(), 0);
    chk("rxto_busy", 32'(busy_o), 0);
    chk("rxto_req_n", req_n, 0);
    clr();
    send('{8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_idle("wr2");
    chk("wr2_addr", log_addr, 32'h0000_0200);
    chk("wr2_wdata", log_wdata, 32'h0102_0304);
    chk("wr2_tx0", txb(0), 32'hA5);
    chk("wr2_err_n", err_n, 0);
    clr();
    ack_en = 0;
    send('{8'h11, 8'hAB, 8'hCD, 8'hEF, 8'h00});
    wait_idle("busto");
    chk("busto_addr", log_addr, 32'hABCD_EF00);
    chk("busto_req_cyc", req_cyc, BUSTO);
    chk("busto_tx_n", txq.size(), 1);
    chk("busto_tx0", txb(0), 32'hEB);
    chk("busto_err_n", err_n, 1);
    clr();
    send('{8'h11, 8'h00, 8'h00, 8'h00, 8'h10});
    begin
      int n = 0;
      while (!mem_req_o && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("mid_req_seen", 32'(mem_req_o), 1);
    end
    repeat (3) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    chk("mid_req", 32'(mem_req_o), 0);
    chk("mid_wr", 32'(uart_wr_o), 0);
    chk("mid_busy", 32'(busy_o), 0);
    rst_i = 0;
    txq.delete();
    repeat (50) @(negedge clk);
    chk("mid_tx_n", txq.size(), 0);
    ack_en = 1;
    chk("wr_while_busy", wr_busy_viol, 0);
    chk("rd_pulse_len", rd_viol, 0);
    chk("wr_pulse_len", wr_viol, 0);
    chk("err_pulse_len", err_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_dbg_ctrl.md
Name: uart_dbg_ctrl

Overview:
Command sequencer that sits between the byte-level UART core and a single-master memory bus, turning host UART frames into 32-bit bus reads/writes. It consumes received bytes with the UART read-acknowledge handshake and paces response bytes against the UART transmit-busy flag. It is the top-level control path of the debug bridge; the UART core and bus fabric are instantiated alongside it.

Parameters:
RX_TIMEOUT_CYC, 1_000_000, max idle cycles between bytes of one frame before abort
BUS_TIMEOUT_CYC, 4096, max cycles waiting for mem_ack_i before abort
TO_W, 20, width of both timeout counters; must hold max(RX_TIMEOUT_CYC, BUS_TIMEOUT_CYC)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
uart_rx_ready_i  in  1  UART received byte valid
uart_data_i  in  8  UART received byte
uart_rd_o  out  1  one-cycle pop of received byte
uart_tx_busy_i  in  1  UART transmitter busy
uart_wr_o  out  1  one-cycle transmit request
uart_data_o  out  8  byte to transmit
mem_req_o  out  1  bus request, held until ack or timeout
mem_we_o  out  1  1=write, 0=read; valid with mem_req_o
mem_addr_o  out  32  byte address
mem_wdata_o  out  32  write data
mem_ack_i  in  1  bus completion, single cycle
mem_rdata_i  in  32  read data, valid with mem_ack_i
busy_o  out  1  high whenever FSM not in IDLE
err_o  out  1  one-cycle pulse on any abort/error

Behaviour:
- Clock clk_i, reset rst_i: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, FSM=IDLE, counters 0; an in-flight bus request is dropped with no response sent.
- Frame (host->bridge): CMD, ADDR[31:24..7:0] MSB first; if CMD=0x10 (write), then DATA 4 bytes MSB first; CMD=0x11 (read) has no data.
- Response: write -> 0xA5; read -> 0xA5 then 4 data bytes MSB first; unknown CMD -> 0xEE; bus timeout -> 0xEB. Inter-byte RX timeout -> no response.
- RX pop: when FSM needs a byte and uart_rx_ready_i=1, capture uart_data_i and pulse uart_rd_o for exactly one cycle; do not sample uart_rx_ready_i in the following cycle (flag clears one cycle after the pop).
- TX push: present uart_data_o and pulse uart_wr_o for one cycle only when uart_tx_busy_i=0; next byte only after busy has been seen high then low again (TX_WAIT).
- States: IDLE -> (byte) decode CMD: 0x10/0x11 -> RX_ADDR; other -> TX_STATUS(0xEE), err_o pulse.
  RX_ADDR: 4 bytes, byte counter 0..3, shift into addr; done -> RX_DATA (write) or BUS_REQ (read).
  RX_DATA: 4 bytes -> BUS_REQ.
  BUS_REQ: mem_req_o=1 with stable addr/we/wdata; mem_ack_i -> latch rdata, TX_STATUS(0xA5); counter reaching BUS_TIMEOUT_CYC -> drop req, TX_STATUS(0xEB), err_o.
  TX_STATUS: send status -> TX_WAIT; then TX_DATA for reads with 0xA5, else IDLE.
  TX_DATA: 4 bytes from latched rdata[31:24] first, each via TX_WAIT -> IDLE.
- RX timeout counter: reset on every popped byte; active only in RX_ADDR/RX_DATA; reaching RX_TIMEOUT_CYC -> IDLE, err_o pulse, partial frame discarded.
- mem_ack_i outside BUS_REQ is ignored. mem_req_o drops the cycle after ack.
- Bytes arriving while in BUS_REQ/TX states are not popped; they stay in the UART buffer (overrun is the UART's behaviour, not corrected here).
- uart_tx_busy_i high after reset (UART startup idle frame): first TX waits naturally.

Decomposition:
- Package uart_dbg_pkg: command codes (CMD_WR=0x10, CMD_RD=0x11), status codes (ST_OK=0xA5, ST_BADCMD=0xEE, ST_BUSTO=0xEB), FSM state enum.
- One natural sub-module: dbg_timeout_cnt (loadable down-counter with expire flag), instantiated twice (RX and bus).

Test Plan:
- Write: RX 10 00 00 01 00 DE AD BE EF -> one mem_req_o, we=1, addr=0x00000100, wdata=0xDEADBEEF; TX 0xA5; busy_o low after.
- Read: RX 11 00 00 00 40, mem_ack_i after 3 cycles with rdata=0x12345678 -> TX A5 12 34 56 78 in order, each uart_wr_o one cycle with busy low.
- Bad command: RX 0x7F -> TX 0xEE, err_o one pulse, no mem_req_o; subsequent valid read frame succeeds.
- RX timeout: RX 10 00 00 then silence > RX_TIMEOUT_CYC -> err_o pulse, IDLE, no TX; next full write frame executes normally.
- Bus timeout: read frame, mem_ack_i never asserted -> mem_req_o drops after BUS_TIMEOUT_CYC cycles, TX 0xEB, err_o pulse.
- Reset mid-operation: assert rst_i during BUS_REQ -> next cycle mem_req_o=0, uart_wr_o=0, busy_o=0; no response byte sent.
